// File: rtl/pll_sup_pkg.sv
// Shared state encoding, default timing constants and helpers for the PLL lock supervisor.
package pll_sup_pkg;

    localparam logic [2:0] S_PLLRST = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_STABLE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;

    typedef enum logic [2:0] {
        ST_PLLRST = S_PLLRST,
        ST_WAIT   = S_WAIT,
        ST_STABLE = S_STABLE,
        ST_HOLD   = S_HOLD,
        ST_RUN    = S_RUN
    } state_t;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT   = 27000;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_HOLD_CYCLES    = 256;
    localparam int DEF_CNT_W          = 8;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage bit synchronizer with asynchronous clear; output is the last flop.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_ff: STAGES must be at least 2");
    end

    // Shift in at bit 0; the cast drops the oldest bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) chain <= '0;
        else     chain <= STAGES'({chain, d});
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives PLLVR RESET, qualifies its LOCK output and releases a clean system reset;
// retries the PLL on lock timeout and counts lock losses.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             pll_lock,
    output logic             pll_reset,
    output logic             sys_reset,
    output logic             locked,
    output logic [CNT_W-1:0] retry_count,
    output logic [CNT_W-1:0] loss_count
);

    localparam int CNT_MAX = max_of4(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, HOLD_CYCLES);
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    if (SYNC_STAGES < 2 || PLL_RST_CYCLES < 1 || LOCK_TIMEOUT < 1 ||
        STABLE_CYCLES < 1 || HOLD_CYCLES < 1 || CNT_W < 1) begin : g_bad_params
        $error("pll_lock_supervisor: illegal parameter value");
    end

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          lock_s;
    logic          retry_inc, loss_inc;

    sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (clkin),
        .rst (reset),
        .d   (pll_lock),
        .q   (lock_s)
    );

    // Loss of lock outranks terminal counts; lock arrival outranks the timeout.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
        case (state)
            ST_PLLRST: begin
                if (cnt == CW'(PLL_RST_CYCLES - 1)) begin
                    state_n = ST_WAIT;
                    cnt_n   = '0;
                end
            end
            ST_WAIT: begin
                if (lock_s) begin
                    state_n = ST_STABLE;
                    cnt_n   = '0;
                end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    state_n   = ST_PLLRST;
                    cnt_n     = '0;
                    retry_inc = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_n = ST_WAIT;
                    cnt_n   = '0;
                end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                    state_n = ST_HOLD;
                    cnt_n   = '0;
                end
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    state_n  = ST_WAIT;
                    cnt_n    = '0;
                    loss_inc = 1'b1;
                end else if (cnt == CW'(HOLD_CYCLES - 1)) begin
                    state_n = ST_RUN;
                    cnt_n   = '0;
                end
            end
            ST_RUN: begin
                cnt_n = cnt;
                if (!lock_s) begin
                    state_n  = ST_WAIT;
                    cnt_n    = '0;
                    loss_inc = 1'b1;
                end
            end
            default: begin
                state_n = ST_PLLRST;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as state.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state       <= ST_PLLRST;
            cnt         <= '0;
            pll_reset   <= 1'b1;
            sys_reset   <= 1'b1;
            locked      <= 1'b0;
            retry_count <= '0;
            loss_count  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pll_reset <= (state_n == ST_PLLRST);
            sys_reset <= (state_n != ST_RUN);
            locked    <= (state_n == ST_RUN);
            if (retry_inc && retry_count != '1) retry_count <= retry_count + 1'b1;
            if (loss_inc && loss_count != '1)   loss_count  <= loss_count + 1'b1;
        end
    end

endmodule
